ram8_loader: RTL and testbench
==============================

RAM8_LOADER -- requirements
Module: ram8_loader

Interface
REQ-001 The block SHALL have parameter WORDS, default 8, meaning the number of words per load burst (legal 1..8).
REQ-002 The block SHALL have parameter BASE_ADDR, default 0, meaning the first RAM8 address written (legal 0..7).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: a one-cycle request to begin a burst.
REQ-006 Port word_in SHALL be an input, 16 bits: the source data word.
REQ-007 Port word_valid SHALL be an input, 1 bit: word_in is valid this cycle.
REQ-008 Port word_ready SHALL be an output, 1 bit: the loader accepts word_in this cycle.
REQ-009 Port ram_in SHALL be an output, 16 bits: data to RAM8 in.
REQ-010 Port ram_addr SHALL be an output, 3 bits: address to RAM8 addr.
REQ-011 Port ram_load SHALL be an output, 1 bit: write strobe to RAM8 load.
REQ-012 Port ram_out SHALL be an input, 16 bits: combinational readback from RAM8 out.
REQ-013 Port busy SHALL be an output, 1 bit: high in every state except IDLE.
REQ-014 Port done SHALL be an output, 1 bit: a one-cycle pulse at burst completion.
REQ-015 Port count SHALL be an output, 4 bits: the number of words written in the current burst.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCEPT, WRITE, VERIFY, CHECK and DONE.
REQ-017 In IDLE with start=1, the FSM SHALL go to ACCEPT, clear count, and clear the checksum.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 word_ready SHALL be 1 only in ACCEPT.
REQ-020 A word SHALL transfer only when word_valid and word_ready are both 1 in the same cycle.
REQ-021 On a transfer, the block SHALL register word_in into ram_in.
REQ-022 On a transfer, the block SHALL set ram_addr to (BASE_ADDR+count) mod 8, wrapping 7 to 0.
REQ-023 On a transfer, the block SHALL XOR word_in into a 16-bit checksum and go to WRITE.
REQ-024 In ACCEPT with word_valid=0, the block SHALL hold its state and all outputs.
REQ-025 WRITE SHALL last exactly one cycle, with ram_load=1 and ram_in/ram_addr stable; count SHALL increment at the end of that cycle.
REQ-026 ram_load SHALL be 0 in every state other than WRITE.
REQ-027 After WRITE, the FSM SHALL go to ACCEPT if count<WORDS; otherwise it SHALL go to VERIFY (macro defined) or DONE (macro undefined).
REQ-028 The minimum throughput SHALL be one word per 2 cycles.
REQ-029 The burst latency from start to done SHALL be 2*WORDS+1 cycles with word_valid held high and no verify, and 3*WORDS+3 cycles with verify.
REQ-030 DONE SHALL assert done=1 for one cycle and then return the FSM to IDLE.
REQ-031 ram_in and ram_addr SHALL hold their last values in IDLE.

Reset
REQ-032 When reset_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-033 When reset_n=0 at a clock edge, the outputs SHALL reset to ram_load=0, word_ready=0, busy=0, done=0, count=0, ram_in=0, ram_addr=BASE_ADDR and verify_err=0, and the checksum SHALL clear.
REQ-034 A reset mid-burst, including during WRITE, SHALL deassert ram_load in the following cycle; the partially loaded RAM contents are not restored.

Configuration
REQ-035 When macro LOADER_VERIFY_EN is defined, the block SHALL add output port verify_err (1 bit) and the VERIFY and CHECK states.
REQ-036 VERIFY SHALL step ram_addr from BASE_ADDR over WORDS cycles, one address per cycle, XORing ram_out into a readback checksum each cycle.
REQ-037 CHECK SHALL last one cycle and set verify_err=1 if the readback checksum differs from the written checksum; verify_err SHALL stay sticky until the next start or reset.
REQ-038 When LOADER_VERIFY_EN is undefined, the port verify_err and the VERIFY and CHECK states SHALL be absent.

Verification
REQ-039 Bench scenario: reset, then start; feed words 0x0001..0x0008 with word_valid held high -> 8 single-cycle ram_load pulses at addresses 0..7, done pulses at cycle 17 without verify or cycle 27 with verify, and count=8.
REQ-040 Bench scenario: BASE_ADDR=6, WORDS=4 -> writes at addresses 6,7,0,1.
REQ-041 Bench scenario: word_valid held low for 5 cycles in ACCEPT -> no ram_load, word_ready stays 1, and ram_in/ram_addr are unchanged.
REQ-042 Bench scenario: start pulsed during WRITE -> ignored, and the burst completes normally.
REQ-043 Bench scenario: reset_n=0 during WRITE of word 3 -> next cycle ram_load=0, busy=0, count=0; a new start restarts at BASE_ADDR.
REQ-044 Bench scenario (LOADER_VERIFY_EN): corrupt RAM word 2 via the bench before VERIFY -> verify_err=1 in the done cycle; a clean run -> verify_err=0.

Source files
------------

// File: rtl/ram8_loader.sv
// Burst loader that streams WORDS source words into a RAM8 starting at BASE_ADDR.
// Optional readback verification is compiled in with macro LOADER_VERIFY_EN.
module ram8_loader #(
    parameter int WORDS     = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [15:0] ram_in,
    output logic [2:0]  ram_addr,
    output logic        ram_load,
    input  logic [15:0] ram_out,
    output logic        busy,
    output logic        done,
    output logic [3:0]  count
`ifdef LOADER_VERIFY_EN
    ,
    output logic        verify_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
`ifdef LOADER_VERIFY_EN
        S_VERIFY,
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] checksum;

`ifdef LOADER_VERIFY_EN
    logic [15:0] rb_sum;
    logic [3:0]  vstep;
`else
    logic unused_in;
    assign unused_in = ^{ram_out, checksum};
`endif

    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        ram_load   = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_IDLE:   if (start) state_next = S_ACCEPT;
            S_ACCEPT: begin
                word_ready = 1'b1;
                if (word_valid) state_next = S_WRITE;
            end
            S_WRITE: begin
                ram_load = 1'b1;
                // count has not yet been bumped for the word being written
                if (count + 4'd1 < 4'(WORDS))
                    state_next = S_ACCEPT;
                else
`ifdef LOADER_VERIFY_EN
                    state_next = S_VERIFY;
`else
                    state_next = S_DONE;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: if (vstep == 4'(WORDS)) state_next = S_CHECK;
            S_CHECK:  state_next = S_DONE;
`endif
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            count    <= 4'd0;
            ram_in   <= 16'd0;
            ram_addr <= 3'(BASE_ADDR);
            checksum <= 16'd0;
`ifdef LOADER_VERIFY_EN
            rb_sum     <= 16'd0;
            vstep      <= 4'd0;
            verify_err <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= 4'd0;
                        checksum <= 16'd0;
`ifdef LOADER_VERIFY_EN
                        rb_sum     <= 16'd0;
                        vstep      <= 4'd0;
                        verify_err <= 1'b0;
`endif
                    end
                end
                S_ACCEPT: begin
                    if (word_valid) begin
                        ram_in   <= word_in;
                        ram_addr <= 3'(BASE_ADDR) + count[2:0];
                        checksum <= checksum ^ word_in;
                    end
                end
                S_WRITE: count <= count + 4'd1;
`ifdef LOADER_VERIFY_EN
                S_VERIFY: begin
                    // first cycle only rewinds the address so ram_out is valid on the next
                    if (vstep == 4'd0) begin
                        ram_addr <= 3'(BASE_ADDR);
                    end else begin
                        rb_sum   <= rb_sum ^ ram_out;
                        ram_addr <= ram_addr + 3'd1;
                    end
                    vstep <= vstep + 4'd1;
                end
                S_CHECK: if (rb_sum != checksum) verify_err <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_loader.sv
// Randomized self-checking bench for ram8_loader: two instances (default and WORDS=4/BASE_ADDR=6)
// each driving a behavioural RAM8; expectations come from burst-level rules.
module tb_ram8_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start      [2];
    logic [15:0] word_in    [2];
    logic        word_valid [2];
    logic        word_ready [2];
    logic [15:0] ram_in     [2];
    logic [2:0]  ram_addr   [2];
    logic        ram_load   [2];
    logic [15:0] ram_out    [2];
    logic        busy       [2];
    logic        done       [2];
    logic [3:0]  count      [2];
`ifdef LOADER_VERIFY_EN
    logic        verify_err [2];
`endif

    logic [15:0] mem [2][8];
    logic        corrupt_on   [2];
    logic [2:0]  corrupt_addr [2];
    int          cyc = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        int          at;
    } wr_t;
    wr_t wrq[$];

    int words_of [2] = '{8, 4};
    int base_of  [2] = '{0, 6};

    int n_checks = 0;
    int n_errors = 0;

    ram8_loader u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .word_in(word_in[0]),
        .word_valid(word_valid[0]), .word_ready(word_ready[0]), .ram_in(ram_in[0]),
        .ram_addr(ram_addr[0]), .ram_load(ram_load[0]), .ram_out(ram_out[0]),
        .busy(busy[0]), .done(done[0]), .count(count[0])
`ifdef LOADER_VERIFY_EN
        , .verify_err(verify_err[0])
`endif
    );

    ram8_loader #(.WORDS(4), .BASE_ADDR(6)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .word_in(word_in[1]),
        .word_valid(word_valid[1]), .word_ready(word_ready[1]), .ram_in(ram_in[1]),
        .ram_addr(ram_addr[1]), .ram_load(ram_load[1]), .ram_out(ram_out[1]),
        .busy(busy[1]), .done(done[1]), .count(count[1])
`ifdef LOADER_VERIFY_EN
        , .verify_err(verify_err[1])
`endif
    );

    // RAM8 model: synchronous write, combinational read; corruption flips bits on readback
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ram_out[k] = mem[k][ram_addr[k]];
            if (corrupt_on[k] && ram_addr[k] == corrupt_addr[k]) ram_out[k] = ram_out[k] ^ 16'h00FF;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (ram_load[k]) begin
                mem[k][ram_addr[k]] <= ram_in[k];
                wrq.push_back('{ram_addr[k], ram_in[k], cyc});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 2; k++) begin
            check("rst_ram_load", ram_load[k], 0);
            check("rst_word_ready", word_ready[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_done", done[k], 0);
            check("rst_count", count[k], 0);
            check("rst_ram_in", ram_in[k], 0);
            check("rst_ram_addr", ram_addr[k], base_of[k]);
`ifdef LOADER_VERIFY_EN
            check("rst_verify_err", verify_err[k], 0);
`endif
        end
    endtask

    // One burst on instance k; checks latency, final state, and the list of RAM writes.
    task automatic run_burst(input int k, input bit seq, input bit gaps, input int stall_at,
                             input bit poke_start, input bit corrupt);
        int          nw;
        int          base;
        int          n;
        int          idx;
        int          exp_lat;
        bit          got_done;
        bit          stalled;
        bit          poked;
        bit          xfer;
        logic [15:0] dq [8];
        logic [15:0] hold_in;
        logic [2:0]  hold_addr;
        nw       = words_of[k];
        base     = base_of[k];
        n        = 1;
        idx      = 0;
        got_done = 0;
        stalled  = 0;
        poked    = 0;
        for (int i = 0; i < 8; i++) dq[i] = seq ? 16'(i + 1) : 16'($urandom);
        wrq.delete();
        corrupt_on[k]   = corrupt;
        corrupt_addr[k] = 3'((base + 2) % 8);

        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        check("busy_after_start", busy[k], 1);
        check("count_cleared", count[k], 0);

        while (n <= 200) begin
            if (done[k]) begin
                got_done = 1;
                break;
            end
            if (word_ready[k] && idx == stall_at && !stalled) begin
                hold_in   = ram_in[k];
                hold_addr = ram_addr[k];
                word_valid[k] = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    n++;
                    check("stall_ready", word_ready[k], 1);
                    check("stall_load", ram_load[k], 0);
                    check("stall_ram_in", ram_in[k], hold_in);
                    check("stall_ram_addr", ram_addr[k], hold_addr);
                end
                stalled = 1;
            end
            if (poke_start && ram_load[k] && !poked) begin
                start[k] = 1'b1;
                poked    = 1;
            end
            word_valid[k] = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            word_in[k]    = (idx < nw) ? dq[idx] : 16'hDEAD;
            xfer = word_ready[k] && word_valid[k];
            @(posedge clk); #1;
            n++;
            start[k] = 1'b0;
            if (xfer) idx++;
        end
        word_valid[k] = 1'b0;
        check("done_seen", got_done, 1);
        if (!got_done) return;

`ifdef LOADER_VERIFY_EN
        exp_lat = 3 * nw + 3;
`else
        exp_lat = 2 * nw + 1;
`endif
        if (stall_at >= 0) exp_lat += 5;
        if (!gaps) check("latency", n, exp_lat);
        check("words_taken", idx, nw);
        check("count_at_done", count[k], nw);
        check("busy_at_done", busy[k], 1);
`ifdef LOADER_VERIFY_EN
        check("verify_err_done", verify_err[k], corrupt);
`endif
        @(posedge clk); #1;
        check("done_one_cycle", done[k], 0);
        check("busy_idle", busy[k], 0);
        check("count_idle", count[k], nw);
`ifdef LOADER_VERIFY_EN
        check("verify_err_sticky", verify_err[k], corrupt);
`endif
        check("n_writes", wrq.size(), nw);
        for (int i = 0; i < nw && i < wrq.size(); i++) begin
            check("wr_addr", wrq[i].addr, (base + i) % 8);
            check("wr_data", wrq[i].data, dq[i]);
            if (i > 0) check("wr_spacing", (wrq[i].at - wrq[i-1].at) >= 2, 1);
        end
        corrupt_on[k] = 1'b0;
    endtask

    task automatic reset_during_write(input int k);
        int          n;
        logic [15:0] dq;
        n = 0;
        wrq.delete();
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        while (!(ram_load[k] && wrq.size() == 2) && n < 50) begin
            dq = 16'($urandom);
            word_in[k]    = dq;
            word_valid[k] = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("reach_write3", n < 50, 1);
        word_valid[k] = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rmid_ram_load", ram_load[k], 0);
        check("rmid_busy", busy[k], 0);
        check("rmid_count", count[k], 0);
        check("rmid_ram_addr", ram_addr[k], base_of[k]);
        check("rmid_word_ready", word_ready[k], 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [15:0] idle_in;
    logic [2:0]  idle_addr;

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k]        = 1'b0;
            word_in[k]      = 16'd0;
            word_valid[k]   = 1'b0;
            corrupt_on[k]   = 1'b0;
            corrupt_addr[k] = 3'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_burst(0, 1, 0, -1, 0, 0);

        idle_in   = ram_in[0];
        idle_addr = ram_addr[0];
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_in", ram_in[0], idle_in);
        check("idle_hold_addr", ram_addr[0], idle_addr);

        run_burst(1, 0, 0, -1, 0, 0);
        run_burst(0, 0, 0, 2, 0, 0);
        run_burst(0, 0, 0, -1, 1, 0);
        reset_during_write(0);
        run_burst(0, 0, 0, -1, 0, 0);

`ifdef LOADER_VERIFY_EN
        run_burst(0, 0, 0, -1, 0, 1);
        run_burst(0, 0, 0, -1, 0, 0);
        run_burst(1, 0, 0, -1, 0, 1);
`endif

        for (int r = 0; r < 6; r++) begin
`ifdef LOADER_VERIFY_EN
            run_burst(r % 2, 0, 1, -1, 0, 1'($urandom_range(0, 1)));
`else
            run_burst(r % 2, 0, 1, -1, 0, 0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
